lc2k_decode_stage: RTL and testbench

//   LC2K instruction-decode pipeline stage, between fetch and execute. Latches fetched

---
 rtl/lc2k_pkg.sv | 61 ++++++
 rtl/lc2k_hazard_unit.sv | 30 +++
 rtl/lc2k_decode_stage.sv | 170 +++++++++++++++++
 tb/tb_lc2k_decode_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc2k_pkg.sv
// LC2K shared decode definitions: opcodes, field positions, decode-stage states and
// per-opcode field-usage helpers.
package lc2k_pkg;

    localparam int unsigned REG_W  = 3;
    localparam int unsigned OP_HI  = 24;
    localparam int unsigned OP_LO  = 22;
    localparam int unsigned RA_HI  = 21;
    localparam int unsigned RA_LO  = 19;
    localparam int unsigned RB_HI  = 18;
    localparam int unsigned RB_LO  = 16;
    localparam int unsigned RD_HI  = 2;
    localparam int unsigned RD_LO  = 0;
    localparam int unsigned OFF_HI = 15;
    localparam int unsigned OFF_LO = 0;
    localparam int unsigned OFF_W  = 16;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        NOR  = 3'd1,
        LW   = 3'd2,
        SW   = 3'd3,
        BEQ  = 3'd4,
        JALR = 3'd5,
        HALT = 3'd6,
        NOOP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } dec_state_t;

    // Register A is read by every opcode except halt/noop.
    function automatic logic uses_a(input opcode_t op);
        return (op != HALT) && (op != NOOP);
    endfunction

    // Register B is a source only where it is not the lw/jalr destination.
    function automatic logic uses_b(input opcode_t op);
        return (op == ADD) || (op == NOR) || (op == SW) || (op == BEQ);
    endfunction

    // Offset field is meaningful only for the I-type memory/branch ops.
    function automatic logic uses_offset(input opcode_t op);
        return (op == LW) || (op == SW) || (op == BEQ);
    endfunction

    // Write-back register; ops without a destination decode to r0.
    function automatic logic [REG_W-1:0] dest_of(input opcode_t op,
                                                 input logic [REG_W-1:0] rb,
                                                 input logic [REG_W-1:0] rd);
        case (op)
            ADD, NOR: return rd;
            LW, JALR: return rb;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/lc2k_hazard_unit.sv
// Load-use hazard detect: the load in ID/EX writes a register the IF/ID instruction reads.
module lc2k_hazard_unit
    import lc2k_pkg::*;
(
    input  logic [OP_HI:0]    instr,
    input  logic              ex_valid,
    input  opcode_t           ex_op,
    input  logic [REG_W-1:0]  ex_dest,
    output logic              hazard
);

    opcode_t          op;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic             unused_fields;

    assign op = opcode_t'(instr[OP_HI:OP_LO]);
    assign ra = instr[RA_HI:RA_LO];
    assign rb = instr[RB_HI:RB_LO];
    assign unused_fields = ^instr[RB_LO-1:0];

    // r0 is not exempt: a load to r0 still stalls a reader of r0.
    always_comb begin
        hazard = 1'b0;
        if (ex_valid && (ex_op == LW)) begin
            hazard = (uses_a(op) && (ra == ex_dest)) || (uses_b(op) && (rb == ex_dest));
        end
    end

endmodule

// File: rtl/lc2k_decode_stage.sv
// LC2K decode stage: IF/ID latch, register-file read addressing, ID/EX latch, load-use
// bubble insertion, branch flush and halt freeze.
// Optional build macro LC2K_DECODE_PERF_EN adds saturating bubble/flush counters.
module lc2k_decode_stage
    import lc2k_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 16
`ifdef LC2K_DECODE_PERF_EN
    ,
    parameter int unsigned PERF_CNT_W = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [PC_W-1:0]       if_pc,
    output logic                  id_ready,
    output logic [REG_W-1:0]      rf_addr1,
    output logic [REG_W-1:0]      rf_addr2,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output opcode_t               ex_op,
    output logic [REG_W-1:0]      ex_dest,
    output logic [XLEN-1:0]       ex_offset,
    output logic [PC_W-1:0]       ex_pc,
    input  logic                  flush,
    output logic                  halted
`ifdef LC2K_DECODE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt
`endif
);

    logic            d_valid;
    logic [OP_HI:0]  d_instr;
    logic [PC_W-1:0] d_pc;
    dec_state_t      state;
    opcode_t         d_op;
    logic            hazard_raw;
    logic            hazard;
    logic            x_adv;
    logic            d_adv;
    logic            issue;
    logic            bubble;
    logic            halt_issue;
    logic            unused_hi_bits;

    assign unused_hi_bits = ^if_instr[31:OP_HI+1];

    assign d_op     = opcode_t'(d_instr[OP_HI:OP_LO]);
    assign rf_addr1 = d_instr[RA_HI:RA_LO];
    assign rf_addr2 = d_instr[RB_HI:RB_LO];

    lc2k_hazard_unit u_hazard (
        .instr    (d_instr),
        .ex_valid (ex_valid),
        .ex_op    (ex_op),
        .ex_dest  (ex_dest),
        .hazard   (hazard_raw)
    );

    assign hazard   = d_valid && hazard_raw;
    assign x_adv    = !ex_valid || ex_ready;
    assign d_adv    = d_valid && !hazard && x_adv;
    // A younger instruction caught behind a HALT is discarded, never issued.
    assign issue      = d_adv && (state != HALTED);
    assign bubble     = hazard && x_adv && (state != HALTED);
    assign halt_issue = issue && (d_op == HALT);
    assign id_ready   = (state != HALTED) && (!d_valid || d_adv);

    // IF/ID and ID/EX pipeline registers; flush kills both and wins over everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid   <= 1'b0;
            d_instr   <= '0;
            d_pc      <= '0;
            ex_valid  <= 1'b0;
            ex_op     <= ADD;
            ex_dest   <= '0;
            ex_offset <= '0;
            ex_pc     <= '0;
        end else if (flush) begin
            d_valid  <= 1'b0;
            ex_valid <= 1'b0;
        end else begin
            if (state == HALTED) begin
                d_valid <= 1'b0;
                d_instr <= '0;
                d_pc    <= '0;
            end else if (id_ready) begin
                d_valid <= if_valid;
                if (if_valid) begin
                    d_instr <= if_instr[OP_HI:0];
                    d_pc    <= if_pc;
                end
            end

            if (issue) begin
                ex_valid  <= 1'b1;
                ex_op     <= d_op;
                ex_dest   <= dest_of(d_op, d_instr[RB_HI:RB_LO], d_instr[RD_HI:RD_LO]);
                ex_offset <= uses_offset(d_op)
                           ? {{(XLEN-OFF_W){d_instr[OFF_HI]}}, d_instr[OFF_HI:OFF_LO]}
                           : '0;
                ex_pc     <= d_pc;
            end else if (x_adv) begin
                ex_valid <= 1'b0;
            end
        end
    end

    // Stage control FSM: one-cycle STALL per bubble, HALTED until flush or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else if (flush) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_issue) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (bubble) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (halt_issue) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef LC2K_DECODE_PERF_EN
    // Saturating counts of inserted bubbles and flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (bubble && !flush && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_CNT_W'(1);
            end
            if (flush && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + PERF_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_lc2k_decode_stage.sv
// Directed self-checking bench for lc2k_decode_stage (optionally built with LC2K_DECODE_PERF_EN).
module tb_lc2k_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
    logic [2:0]  rf_addr1;
    logic [2:0]  rf_addr2;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_op;
    logic [2:0]  ex_dest;
    logic [31:0] ex_offset;
    logic [15:0] ex_pc;
    logic        flush;
    logic        halted;
`ifdef LC2K_DECODE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    lc2k_decode_stage dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .id_ready  (id_ready),
        .rf_addr1  (rf_addr1),
        .rf_addr2  (rf_addr2),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_dest   (ex_dest),
        .ex_offset (ex_offset),
        .ex_pc     (ex_pc),
        .flush     (flush),
        .halted    (halted)
`ifdef LC2K_DECODE_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {ex_valid, ex_op, ex_dest, ex_offset, ex_pc}
    function automatic logic [54:0] ex_bus();
        return {ex_valid, ex_op, ex_dest, ex_offset, ex_pc};
    endfunction

    // {id_ready, rf_addr1, rf_addr2, ex_bus, halted}
    function automatic logic [62:0] all_outs();
        return {id_ready, rf_addr1, rf_addr2, ex_bus(), halted};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (all_outs() !== {1'b1, 6'd0, 55'd0, 1'b0}) begin
            n_err++; $display("FAIL reset_outputs got=%h want=%h", all_outs(), {1'b1, 6'd0, 55'd0, 1'b0});
        end
    endtask

    task automatic test_add();
        do_reset();
        if_valid = 1'b1; if_instr = 32'h000A0003; if_pc = 16'h0040;
        tick();
        if_valid = 1'b0;
        n_vec++;
        if ({rf_addr1, rf_addr2, ex_valid} !== {3'd1, 3'd2, 1'b0}) begin
            n_err++; $display("FAIL add_rf_addr got=%h want=%h", {rf_addr1, rf_addr2, ex_valid}, {3'd1, 3'd2, 1'b0});
        end
        tick();
        n_vec++;
        if (ex_bus() !== {1'b1, 3'd0, 3'd3, 32'h0, 16'h0040}) begin
            n_err++; $display("FAIL add_ex got=%h want=%h", ex_bus(), {1'b1, 3'd0, 3'd3, 32'h0, 16'h0040});
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL add_drain got=%b want=0", ex_valid);
        end
    endtask

    task automatic test_sw_offset();
        do_reset();
        if_valid = 1'b1; if_instr = 32'h00C1FFFF; if_pc = 16'h0011;
        tick();
        if_valid = 1'b0;
        n_vec++;
        if ({rf_addr1, rf_addr2} !== {3'd0, 3'd1}) begin
            n_err++; $display("FAIL sw_rf_addr got=%h want=%h", {rf_addr1, rf_addr2}, {3'd0, 3'd1});
        end
        tick();
        n_vec++;
        if (ex_bus() !== {1'b1, 3'd3, 3'd0, 32'hFFFFFFFF, 16'h0011}) begin
            n_err++; $display("FAIL sw_ex got=%h want=%h", ex_bus(), {1'b1, 3'd3, 3'd0, 32'hFFFFFFFF, 16'h0011});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        if_valid = 1'b1; if_instr = 32'h008A0005; if_pc = 16'h0001;
        tick();
        if_instr = 32'h00120003; if_pc = 16'h0002;
        n_vec++;
        if (id_ready !== 1'b1) begin
            n_err++; $display("FAIL lu_accept_add got=%b want=1", id_ready);
        end
        tick();
        if_valid = 1'b0;
        n_vec++;
        if ({ex_bus(), id_ready} !== {1'b1, 3'd2, 3'd2, 32'd5, 16'h0001, 1'b0}) begin
            n_err++; $display("FAIL lu_hazard got=%h want=%h", {ex_bus(), id_ready}, {1'b1, 3'd2, 3'd2, 32'd5, 16'h0001, 1'b0});
        end
        tick();
        n_vec++;
        if ({ex_valid, id_ready} !== 2'b01) begin
            n_err++; $display("FAIL lu_bubble got=%b want=01", {ex_valid, id_ready});
        end
`ifdef LC2K_DECODE_PERF_EN
        n_vec++;
        if (perf_stall_cnt !== 32'd1) begin
            n_err++; $display("FAIL lu_perf_stall got=%0d want=1", perf_stall_cnt);
        end
`endif
        tick();
        n_vec++;
        if (ex_bus() !== {1'b1, 3'd0, 3'd3, 32'h0, 16'h0002}) begin
            n_err++; $display("FAIL lu_add_issue got=%h want=%h", ex_bus(), {1'b1, 3'd0, 3'd3, 32'h0, 16'h0002});
        end
    endtask

    task automatic test_halt();
        do_reset();
        if_valid = 1'b1; if_instr = 32'h01800000; if_pc = 16'h0005;
        tick();
        if_instr = 32'h01C00000; if_pc = 16'h0006;
        tick();
        n_vec++;
        if ({halted, id_ready, ex_bus()} !== {1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 32'h0, 16'h0005}) begin
            n_err++; $display("FAIL halt_enter got=%h want=%h", {halted, id_ready, ex_bus()}, {1'b1, 1'b0, 1'b1, 3'd6, 3'd0, 32'h0, 16'h0005});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({halted, id_ready, ex_valid} !== 3'b100) begin
                n_err++; $display("FAIL halt_hold[%0d] got=%b want=100", i, {halted, id_ready, ex_valid});
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        n_vec++;
        if ({halted, id_ready, ex_valid} !== 3'b010) begin
            n_err++; $display("FAIL halt_flush got=%b want=010", {halted, id_ready, ex_valid});
        end
`ifdef LC2K_DECODE_PERF_EN
        n_vec++;
        if (perf_flush_cnt !== 32'd1) begin
            n_err++; $display("FAIL halt_perf_flush got=%0d want=1", perf_flush_cnt);
        end
`endif
    endtask

    task automatic test_ex_backpressure();
        do_reset();
        ex_ready = 1'b0;
        if_valid = 1'b1; if_instr = 32'h000A0003; if_pc = 16'h0020;
        tick();
        if_instr = 32'h00530001; if_pc = 16'h0021;
        tick();
        if_instr = 32'h000A0003; if_pc = 16'h0022;
        n_vec++;
        if ({ex_bus(), id_ready} !== {1'b1, 3'd0, 3'd3, 32'h0, 16'h0020, 1'b0}) begin
            n_err++; $display("FAIL bp_full got=%h want=%h", {ex_bus(), id_ready}, {1'b1, 3'd0, 3'd3, 32'h0, 16'h0020, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({ex_bus(), id_ready, rf_addr1, rf_addr2} !== {1'b1, 3'd0, 3'd3, 32'h0, 16'h0020, 1'b0, 3'd2, 3'd3}) begin
                n_err++; $display("FAIL bp_hold[%0d] got=%h want=%h", i, {ex_bus(), id_ready, rf_addr1, rf_addr2}, {1'b1, 3'd0, 3'd3, 32'h0, 16'h0020, 1'b0, 3'd2, 3'd3});
            end
        end
        ex_ready = 1'b1;
        tick();
        if_valid = 1'b0; ex_ready = 1'b0;
        n_vec++;
        if (ex_bus() !== {1'b1, 3'd1, 3'd1, 32'h0, 16'h0021}) begin
            n_err++; $display("FAIL bp_release got=%h want=%h", ex_bus(), {1'b1, 3'd1, 3'd1, 32'h0, 16'h0021});
        end
        tick();
        flush = 1'b1;
        n_vec++;
        if (ex_bus() !== {1'b1, 3'd1, 3'd1, 32'h0, 16'h0021}) begin
            n_err++; $display("FAIL bp_stable got=%h want=%h", ex_bus(), {1'b1, 3'd1, 3'd1, 32'h0, 16'h0021});
        end
        tick();
        flush = 1'b0; ex_ready = 1'b1;
        n_vec++;
        if ({ex_valid, id_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_flush got=%b want=01", {ex_valid, id_ready});
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_flush_kills_ifid got=%b want=0", ex_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        if_valid = 1'b1; if_instr = 32'h008A0005; if_pc = 16'h0030;
        tick();
        if_instr = 32'h001C0005; if_pc = 16'h0031;
        tick();
        if_instr = 32'h0109FFFE; if_pc = 16'h0032;
        n_vec++;
        if ({ex_bus(), id_ready} !== {1'b1, 3'd2, 3'd2, 32'd5, 16'h0030, 1'b1}) begin
            n_err++; $display("FAIL b2b_lw got=%h want=%h", {ex_bus(), id_ready}, {1'b1, 3'd2, 3'd2, 32'd5, 16'h0030, 1'b1});
        end
        tick();
        if_valid = 1'b0;
        n_vec++;
        if (ex_bus() !== {1'b1, 3'd0, 3'd5, 32'h0, 16'h0031}) begin
            n_err++; $display("FAIL b2b_add got=%h want=%h", ex_bus(), {1'b1, 3'd0, 3'd5, 32'h0, 16'h0031});
        end
        tick();
        n_vec++;
        if (ex_bus() !== {1'b1, 3'd4, 3'd0, 32'hFFFFFFFE, 16'h0032}) begin
            n_err++; $display("FAIL b2b_beq got=%h want=%h", ex_bus(), {1'b1, 3'd4, 3'd0, 32'hFFFFFFFE, 16'h0032});
        end
    endtask

    task automatic test_flush_override();
        do_reset();
        if_valid = 1'b1; if_instr = 32'h000A0003; if_pc = 16'h0040;
        tick();
        if_instr = 32'h00530001; if_pc = 16'h0041; flush = 1'b1;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        n_vec++;
        if ({ex_valid, id_ready} !== 2'b01) begin
            n_err++; $display("FAIL fo_flush got=%b want=01", {ex_valid, id_ready});
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL fo_no_accept got=%b want=0", ex_valid);
        end
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        if_valid = 1'b1; if_instr = 32'h008A0005; if_pc = 16'h0001;
        tick();
        if_instr = 32'h00120003; if_pc = 16'h0002;
        tick();
        if_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (all_outs() !== {1'b1, 6'd0, 55'd0, 1'b0}) begin
            n_err++; $display("FAIL rst_stall_outputs got=%h want=%h", all_outs(), {1'b1, 6'd0, 55'd0, 1'b0});
        end
`ifdef LC2K_DECODE_PERF_EN
        n_vec++;
        if (perf_stall_cnt !== 32'd0) begin
            n_err++; $display("FAIL rst_perf_stall got=%0d want=0", perf_stall_cnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_no_replay got=%b want=0", ex_valid);
        end
        // Asynchronous reset out of HALTED as well.
        if_valid = 1'b1; if_instr = 32'h01800000; if_pc = 16'h0007;
        tick();
        if_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({halted, id_ready, ex_valid} !== 3'b010) begin
            n_err++; $display("FAIL rst_halt got=%b want=010", {halted, id_ready, ex_valid});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_ready = 1'b1; flush = 1'b0;
        test_reset();
        test_add();
        test_sw_offset();
        test_load_use();
        test_halt();
        test_ex_backpressure();
        test_back_to_back();
        test_flush_override();
        test_rst_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d vectors", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
